// File: rtl/audio_sample_scheduler_pkg.sv
// Shared constants and types for the audio sample scheduler.
package audio_sample_scheduler_pkg;

  localparam int unsigned AUDIO_BIT_WIDTH   = 16;
  localparam int unsigned AUDIO_CLOCK       = 16_934_400;
  localparam int unsigned AUDIO_SAMPLE_RATE = 44_100;

  // Audio clocks per output sample (384 at 44.1 kHz).
  localparam int unsigned SAMPLE_TICKS = AUDIO_CLOCK / AUDIO_SAMPLE_RATE;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } scheduler_state_t;

endpackage

// File: rtl/audio_sample_scheduler_if.sv
// Synth-to-scheduler sample handshake.
interface audio_sample_scheduler_if
  import audio_sample_scheduler_pkg::*;
#(
  parameter int unsigned W = AUDIO_BIT_WIDTH
) ();

  logic         sample_valid;
  logic [W-1:0] sample_data;
  logic         sample_ready;

  // Synthesizer side offers samples.
  modport master (
    output sample_valid,
    output sample_data,
    input  sample_ready
  );

  // Scheduler side accepts samples.
  modport slave (
    input  sample_valid,
    input  sample_data,
    output sample_ready
  );

endinterface

// File: rtl/audio_sample_scheduler_sample_fifo.sv
// Small synchronous FIFO; pointers carry an extra wrap bit so full and
// empty are distinguished without a separate counter.
module sample_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      w_level;
  logic             w_full;
  logic             w_empty;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_level = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_level == (AW+1)'(DEPTH));
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  // A pop frees the head slot this cycle, so a push at full is accepted
  // alongside it; flush discards both.
  assign w_do_pop  = i_pop && !w_empty && !i_flush;
  assign w_do_push = i_push && !i_flush && (!w_full || w_do_pop);

  // Pointer update; flush returns both pointers to the origin.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; the head read below sees the pre-write contents.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_level = w_level;

endmodule

// File: rtl/audio_sample_scheduler.sv
// Buffers synth samples and releases one per sample period to the DAC
// driver, holding audio_out stable between ticks; mutes and counts underruns.
module audio_sample_scheduler
  import audio_sample_scheduler_pkg::*;
#(
  parameter int unsigned AUDIO_BIT_WIDTH = audio_sample_scheduler_pkg::AUDIO_BIT_WIDTH,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned SAMPLE_TICKS    = audio_sample_scheduler_pkg::SAMPLE_TICKS
) (
  input  logic                          clock_16_934_400,
  input  logic                          reset_l,
  input  logic                          enable,
  input  logic                          underrun_clear,
  audio_sample_scheduler_if.slave       synth,
  output logic [AUDIO_BIT_WIDTH-1:0]    audio_out,
  output logic                          sample_tick,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    underrun_count,
  output logic                          running
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PW = (SAMPLE_TICKS > 1) ? $clog2(SAMPLE_TICKS) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(SAMPLE_TICKS - 1);

  scheduler_state_t           r_state;
  scheduler_state_t           w_state_nxt;
  logic [PW-1:0]              r_phase;
  logic [AUDIO_BIT_WIDTH-1:0] r_audio;
  logic [7:0]                 r_underrun;

  logic                       w_ready;
  logic                       w_tick;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_flush;
  logic                       w_full;
  logic                       w_empty;
  logic [LW-1:0]              w_level;
  logic [AUDIO_BIT_WIDTH-1:0] w_head;

  assign w_tick  = (r_state == RUN) && (r_phase == PHASE_LAST);
  assign w_flush = !enable;
  assign w_push  = synth.sample_valid && w_ready && enable;
  assign w_pop   = w_tick && !w_empty && enable;

  sample_fifo #(
    .WIDTH (AUDIO_BIT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clock_16_934_400),
    .i_rst_n (reset_l),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (synth.sample_data),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // State register.
  always_ff @(posedge clock_16_934_400 or negedge reset_l) begin
    if (!reset_l) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and ready. Ready at full in RUN relies on the tick pop
  // freeing a slot, so it depends only on registered state and phase.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) w_state_nxt = PRIME;
      end
      PRIME: begin
        w_ready = !w_full;
        if (!enable) begin
          w_state_nxt = IDLE;
        end else if (w_full ||
                     (synth.sample_valid && !w_full &&
                      (w_level == LW'(FIFO_DEPTH - 1)))) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_ready = !w_full || w_tick;
        if (!enable) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Sample-period phase counter; free-runs only while in RUN.
  always_ff @(posedge clock_16_934_400 or negedge reset_l) begin
    if (!reset_l)                          r_phase <= '0;
    else if (!enable || r_state != RUN)    r_phase <= '0;
    else if (r_phase == PHASE_LAST)        r_phase <= '0;
    else                                   r_phase <= r_phase + PW'(1);
  end

  // Output sample register: head on tick, silence on underrun or leaving.
  always_ff @(posedge clock_16_934_400 or negedge reset_l) begin
    if (!reset_l)     r_audio <= '0;
    else if (!enable) r_audio <= '0;
    else if (w_tick)  r_audio <= w_empty ? '0 : w_head;
  end

  // Saturating underrun counter; clear wins over a simultaneous increment.
  always_ff @(posedge clock_16_934_400 or negedge reset_l) begin
    if (!reset_l)
      r_underrun <= '0;
    else if (underrun_clear)
      r_underrun <= '0;
    else if (enable && w_tick && w_empty && (r_underrun != '1))
      r_underrun <= r_underrun + 8'd1;
  end

  assign synth.sample_ready = w_ready;
  assign audio_out          = r_audio;
  assign sample_tick        = w_tick;
  assign fifo_level         = w_level;
  assign underrun_count     = r_underrun;
  assign running            = (r_state == RUN);

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Self-checking bench for audio_sample_scheduler against a queue-based model.
module tb_audio_sample_scheduler;

  localparam int unsigned W = 16;
  localparam int unsigned D = 4;
  localparam int unsigned T = 24;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic         underrun_clear;
  logic [W-1:0] audio_out;
  logic         sample_tick;
  logic [$clog2(D):0] fifo_level;
  logic [7:0]   underrun_count;
  logic         running;

  audio_sample_scheduler_if #(.W(W)) bus ();

  audio_sample_scheduler #(
    .AUDIO_BIT_WIDTH (W),
    .FIFO_DEPTH      (D),
    .SAMPLE_TICKS    (T)
  ) dut (
    .clock_16_934_400 (clk),
    .reset_l          (rst_n),
    .enable           (enable),
    .underrun_clear   (underrun_clear),
    .synth            (bus),
    .audio_out        (audio_out),
    .sample_tick      (sample_tick),
    .fifo_level       (fifo_level),
    .underrun_count   (underrun_count),
    .running          (running)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: buffered samples, activity flags, cycles spent running.
  logic [W-1:0] q[$];
  bit           m_active;
  bit           m_running;
  int           m_runcyc;
  logic [W-1:0] m_audio;
  int           m_under;

  bit obs_tick;
  bit obs_running;
  logic [W-1:0] seq;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_tick();
    return m_running && ((m_runcyc % T) == (T - 1));
  endfunction

  function automatic bit m_ready();
    if (!m_active) return 1'b0;
    return (q.size() < D) || (m_tick() && q.size() > 0);
  endfunction

  function automatic void model_reset();
    q.delete();
    m_active  = 0;
    m_running = 0;
    m_runcyc  = 0;
    m_audio   = '0;
    m_under   = 0;
  endfunction

  function automatic void model_update(input logic en, input logic vld,
                                       input logic [W-1:0] dat, input logic clr);
    bit tk;
    bit push;
    tk   = m_tick();
    push = vld && m_ready();
    if (!en) begin
      q.delete();
      m_active  = 0;
      m_running = 0;
      m_runcyc  = 0;
      m_audio   = '0;
    end else if (!m_active) begin
      m_active = 1;
    end else begin
      if (m_running) begin
        if (tk) begin
          if (q.size() > 0) m_audio = q.pop_front();
          else begin
            m_audio = '0;
            if (m_under < 255) m_under++;
          end
        end
        m_runcyc++;
      end
      if (push) q.push_back(dat);
      if (!m_running && q.size() == D) begin
        m_running = 1;
        m_runcyc  = 0;
      end
    end
    if (clr) m_under = 0;
  endfunction

  task automatic step(input logic en, input logic vld, input logic [W-1:0] dat, input logic clr);
    enable           = en;
    bus.sample_valid = vld;
    bus.sample_data  = dat;
    underrun_clear   = clr;
    #2;
    obs_tick    = sample_tick;
    obs_running = running;
    check_val("sample_ready",   {31'd0, bus.sample_ready}, {31'd0, m_ready()});
    check_val("sample_tick",    {31'd0, sample_tick},      {31'd0, m_tick()});
    check_val("running",        {31'd0, running},          {31'd0, m_running});
    check_val("fifo_level",     32'(fifo_level),           32'(q.size()));
    check_val("audio_out",      32'(audio_out),            32'(m_audio));
    check_val("underrun_count", 32'(underrun_count),       32'(m_under));
    @(posedge clk);
    model_update(en, vld, dat, clr);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ready"},   {31'd0, bus.sample_ready}, 32'd0);
    check_val({tag, "_audio"},   32'(audio_out),            32'd0);
    check_val({tag, "_tick"},    {31'd0, sample_tick},      32'd0);
    check_val({tag, "_level"},   32'(fifo_level),           32'd0);
    check_val({tag, "_under"},   32'(underrun_count),       32'd0);
    check_val({tag, "_running"}, {31'd0, running},          32'd0);
  endtask

  // Counts RUN cycles up to and including the first tick.
  task automatic measure_first_tick(input string tag);
    int k = 0;
    int budget = 0;
    bit seen = 0;
    while (!seen && budget < 20 * T) begin
      seq = seq + 1'b1;
      step(1'b1, 1'b1, seq, 1'b0);
      budget++;
      if (obs_running) begin
        k++;
        if (obs_tick) seen = 1;
      end
    end
    if (!seen) check_val({tag, "_timeout"}, 32'd0, 32'd1);
    else       check_val(tag, 32'(k), 32'(T));
  endtask

  task automatic refill_to_full(input string tag);
    int budget = 0;
    while (!(m_running && q.size() == D) && budget < 20 * T) begin
      step(1'b1, 1'b1, W'($urandom), 1'b0);
      budget++;
    end
    if (!(m_running && q.size() == D)) check_val({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic random_run(input int cycles);
    int bias;
    for (int i = 0; i < cycles; i++) begin
      if ((i % 200) == 0) bias = int'($urandom_range(0, 3));
      step(($urandom % 400) != 0,
           ($urandom % 4) <= bias,
           W'($urandom),
           ($urandom % 150) == 0);
    end
  endtask

  initial begin
    int budget;
    bit t;
    int u;
    rst_n            = 1'b0;
    enable           = 1'b0;
    underrun_clear   = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_data  = '0;
    seq              = '0;
    model_reset();

    // Reset state.
    #3;
    check_all_zero("reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) step(1'b0, 1'b0, '0, 1'b0);

    // Prime with incrementing data and stream with valid held high.
    measure_first_tick("first_tick_latency");
    repeat (4 * T) begin
      seq = seq + 1'b1;
      step(1'b1, 1'b1, seq, 1'b0);
    end

    // Starve: underruns, then saturation.
    repeat (6 * T) step(1'b1, 1'b0, '0, 1'b0);
    repeat (300 * T) step(1'b1, 1'b0, '0, 1'b0);
    check_val("underrun_saturated", 32'(underrun_count), 32'd255);

    // Clear coinciding with an underrun tick.
    budget = 0;
    t = 0;
    while (!t && budget < 2 * T) begin
      t = m_tick();
      step(1'b1, 1'b0, '0, t);
      budget++;
    end
    if (!t) check_val("clr_on_tick_timeout", 32'd0, 32'd1);
    else    check_val("clr_on_tick", 32'(underrun_count), 32'd0);

    // Build some underruns, refill, drain to three, then drop enable.
    repeat (3 * T) step(1'b1, 1'b0, '0, 1'b0);
    refill_to_full("refill");
    budget = 0;
    while (q.size() != 3 && budget < 3 * T) begin
      step(1'b1, 1'b0, '0, 1'b0);
      budget++;
    end
    if (q.size() != 3) check_val("drain3_timeout", 32'd0, 32'd1);
    u = m_under;
    step(1'b0, 1'b1, W'($urandom), 1'b0);
    check_val("drop_level",   32'(fifo_level),      32'd0);
    check_val("drop_audio",   32'(audio_out),       32'd0);
    check_val("drop_running", {31'd0, running},     32'd0);
    check_val("drop_under",   32'(underrun_count),  32'(u));
    repeat (2 * T) step(1'b0, 1'b1, W'($urandom), 1'b0);

    // Randomized traffic with occasional enable drops and clears.
    random_run(3000);

    // Asynchronous reset pulse mid-RUN, then re-prime.
    refill_to_full("pre_reset");
    repeat (T + 5) step(1'b1, 1'b1, W'($urandom), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    measure_first_tick("retick_after_reset");
    random_run(2000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
